uart_mmio: RTL and testbench

Memory-mapped UART that sits directly upstream of the AVR core's data bus: drives the byte multiplexed onto the CPU read path and consumes CPU writes, bridging to the FTDI port-B pins (ftdi_rx/ftdi_tx). It has an 8N1 receiver feeding an RX FIFO, a single-byte transmitter, and a status/control register. Address decode of the window is done by the top-level bus mux; this block sees only a chip select and a 2-bit register offset.

---
 rtl/uart_mmio.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with an RX FIFO, a single-byte transmitter
// and status/control registers, sitting on the CPU data bus.
module uart_mmio #(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cs,
    input  logic [1:0] address,
    input  logic       rd,
    input  logic       wren,
    input  logic [7:0] data_wr,
    output logic [7:0] q,
    output logic       irq,
    input  logic       rx,
    output logic       tx
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;

    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DIV - 1);
    localparam logic [CW-1:0]    FIFO_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Synchroniser and edge history
    logic r_rx_meta, r_rx_sync, r_rx_prev;

    // Receiver state
    rx_state_t        r_rx_state, w_rx_state_nx;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nx;
    logic [2:0]       r_rx_idx, w_rx_idx_nx;
    logic [7:0]       r_rx_shift, w_rx_shift_nx;
    logic             r_rx_wait, w_rx_wait_nx;
    logic             w_rx_push, w_ferr_set;

    // Transmitter state
    tx_state_t        r_tx_state, w_tx_state_nx;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nx;
    logic [2:0]       r_tx_idx, w_tx_idx_nx;
    logic [7:0]       r_tx_shift, w_tx_shift_nx;
    logic             r_tx, w_tx_nx;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;

    // Flags and control
    logic r_ovr, r_ferr, r_irqen, r_irq;

    // Bus decode and FIFO handshake
    logic w_wr, w_wr_data, w_wr_status, w_wr_ctrl;
    logic w_fifo_empty, w_fifo_full, w_pop, w_push_ok, w_ovr_set;
    logic w_txrdy, w_tx_start;

    assign w_wr        = cs & wren;
    assign w_wr_data   = w_wr & (address == ADDR_DATA);
    assign w_wr_status = w_wr & (address == ADDR_STATUS);
    assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == FIFO_FULL);
    assign w_pop        = cs & rd & (address == ADDR_DATA) & ~w_fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok    = w_rx_push & (~w_fifo_full | w_pop);
    assign w_ovr_set    = w_rx_push & w_fifo_full & ~w_pop;

    assign w_txrdy    = (r_tx_state == TX_IDLE);
    assign w_tx_start = w_wr_data & w_txrdy;

    // Two-flop synchroniser on rx plus one delayed copy for falling-edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Receiver state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_wait  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_idx   <= w_rx_idx_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_rx_wait  <= w_rx_wait_nx;
        end
    end

    // Receiver next-state: mid-bit sampling, LSB first; a bad stop bit holds until the line idles
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_idx_nx   = r_rx_idx;
        w_rx_shift_nx = r_rx_shift;
        w_rx_wait_nx  = r_rx_wait;
        w_rx_push     = 1'b0;
        w_ferr_set    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state_nx = RX_START;
                    w_rx_cnt_nx   = CNT_HALF;
                end
            end
            RX_START: begin
                if (r_rx_cnt == '0) begin
                    if (r_rx_sync) begin
                        w_rx_state_nx = RX_IDLE;
                    end else begin
                        w_rx_state_nx = RX_DATA;
                        w_rx_cnt_nx   = CNT_FULL;
                        w_rx_idx_nx   = 3'd0;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == '0) begin
                    w_rx_shift_nx = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_cnt_nx   = CNT_FULL;
                    if (r_rx_idx == 3'd7) begin
                        w_rx_state_nx = RX_STOP;
                    end else begin
                        w_rx_idx_nx = r_rx_idx + 3'd1;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt - CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (r_rx_wait) begin
                    if (r_rx_sync) begin
                        w_rx_wait_nx  = 1'b0;
                        w_rx_state_nx = RX_IDLE;
                    end
                end else if (r_rx_cnt == '0) begin
                    if (r_rx_sync) begin
                        w_rx_push     = 1'b1;
                        w_rx_state_nx = RX_IDLE;
                    end else begin
                        w_ferr_set   = 1'b1;
                        w_rx_wait_nx = 1'b1;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_rx_state_nx = RX_IDLE;
            end
        endcase
    end

    // FIFO storage; contents are meaningless while empty so no reset is needed
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_rx_shift;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags (set beats clear), interrupt enable and registered interrupt
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
            r_irqen <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (w_wr_status && data_wr[2]) begin
                r_ovr <= 1'b0;
            end
            if (w_ferr_set) begin
                r_ferr <= 1'b1;
            end else if (w_wr_status && data_wr[3]) begin
                r_ferr <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_irqen <= data_wr[0];
            end
            r_irq <= r_irqen & (~w_fifo_empty | r_ovr | r_ferr);
        end
    end

    // Transmitter state register; tx idles high
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_idx   <= w_tx_idx_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_tx       <= w_tx_nx;
        end
    end

    // Transmitter next-state: each of the ten bits is held for DIV clocks
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_idx_nx   = r_tx_idx;
        w_tx_shift_nx = r_tx_shift;
        w_tx_nx       = r_tx;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_nx = 1'b1;
                if (w_tx_start) begin
                    w_tx_state_nx = TX_START;
                    w_tx_cnt_nx   = CNT_FULL;
                    w_tx_shift_nx = data_wr;
                    w_tx_nx       = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt == '0) begin
                    w_tx_state_nx = TX_DATA;
                    w_tx_cnt_nx   = CNT_FULL;
                    w_tx_idx_nx   = 3'd0;
                    w_tx_nx       = r_tx_shift[0];
                    w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                end else begin
                    w_tx_cnt_nx = r_tx_cnt - CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == '0) begin
                    w_tx_cnt_nx = CNT_FULL;
                    if (r_tx_idx == 3'd7) begin
                        w_tx_state_nx = TX_STOP;
                        w_tx_nx       = 1'b1;
                    end else begin
                        w_tx_idx_nx   = r_tx_idx + 3'd1;
                        w_tx_nx       = r_tx_shift[0];
                        w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                    end
                end else begin
                    w_tx_cnt_nx = r_tx_cnt - CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == '0) begin
                    w_tx_state_nx = TX_IDLE;
                end else begin
                    w_tx_cnt_nx = r_tx_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_tx_state_nx = TX_IDLE;
                w_tx_nx       = 1'b1;
            end
        endcase
    end

    // Read mux: combinational from the register offset
    always_comb begin
        q = 8'h00;
        case (address)
            ADDR_DATA:   q = w_fifo_empty ? 8'h00 : r_mem[r_rptr];
            ADDR_STATUS: q = {4'b0000, r_ferr, r_ovr, w_txrdy, ~w_fifo_empty};
            ADDR_CTRL:   q = {7'b0000000, r_irqen};
            default:     q = 8'h00;
        endcase
    end

    assign irq = r_irq;
    assign tx  = r_tx;

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scenario-driven bench for uart_mmio with a queue-based RX model.
module tb_uart_mmio;

    localparam int unsigned DIV = 25000000 / 115200;

    logic       clock;
    logic       reset_n;
    logic       cs;
    logic [1:0] address;
    logic       rd;
    logic       wren;
    logic [7:0] data_wr;
    logic [7:0] q;
    logic       irq;
    logic       rx;
    logic       tx;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: received bytes in order plus sticky flags
    logic [7:0] model_q[$];
    bit         m_ovr  = 1'b0;
    bit         m_ferr = 1'b0;

    uart_mmio dut (
        .clock   (clock),
        .reset_n (reset_n),
        .cs      (cs),
        .address (address),
        .rd      (rd),
        .wren    (wren),
        .data_wr (data_wr),
        .q       (q),
        .irq     (irq),
        .rx      (rx),
        .tx      (tx)
    );

    initial begin
        clock = 1'b0;
        forever #20 clock = ~clock;
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_status();
        return {4'b0000, m_ferr, m_ovr, 1'b1, model_q.size() != 0};
    endfunction

    // Spec-level receive rule: good frame pushes or overflows, bad stop bit only flags
    task automatic model_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) m_ferr = 1'b1;
        else if (model_q.size() < 16) model_q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic peek(input logic [1:0] a, output logic [7:0] v);
        cs = 1'b1; address = a; rd = 1'b0;
        #1;
        v = q;
        cs = 1'b0; address = 2'd0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; wren = 1'b1; address = a; data_wr = d;
        @(posedge clock); #1;
        cs = 1'b0; wren = 1'b0; address = 2'd0; data_wr = 8'h00;
    endtask

    task automatic bus_pop(output logic [7:0] v);
        cs = 1'b1; rd = 1'b1; address = 2'd0;
        #1;
        v = q;
        @(posedge clock); #1;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) rx = 1'b0;
            else if (i == 9) rx = stop;
            else rx = b[i-1];
            repeat (DIV) @(posedge clock);
            #1;
        end
        rx = 1'b1;
    endtask

    // Transmit one byte and watch every cycle of the frame
    task automatic check_tx(input logic [7:0] b, input bit stray);
        logic [9:0] frame;
        logic [7:0] s;
        bit ok;
        frame = {1'b1, b, 1'b0};
        bus_write(2'd0, b);
        peek(2'd1, s);
        n_checks++;
        if (s[1] !== 1'b0) begin
            n_fail++; $display("FAIL txrdy_after_write: got %b expected 0", s[1]);
        end
        for (int bi = 0; bi < 10; bi++) begin
            ok = 1'b1;
            for (int c = 0; c < int'(DIV); c++) begin
                if (tx !== frame[bi]) ok = 1'b0;
                if (bi == 9 && c == int'(DIV) - 1) begin
                    peek(2'd1, s);
                    n_checks++;
                    if (s[1] !== 1'b0) begin
                        n_fail++; $display("FAIL txrdy_last_cycle: got %b expected 0", s[1]);
                    end
                end
                if (stray && bi == 2 && c == 10) begin
                    cs = 1'b1; wren = 1'b1; address = 2'd0; data_wr = ~b;
                end
                @(posedge clock); #1;
                cs = 1'b0; wren = 1'b0; data_wr = 8'h00;
            end
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL tx_bit%0d byte %h: line not held at %b for %0d clocks", bi, b, frame[bi], DIV);
            end
        end
        peek(2'd1, s);
        n_checks++;
        if (s[1] !== 1'b1 || tx !== 1'b1) begin
            n_fail++; $display("FAIL tx_done: txrdy=%b tx=%b expected 1 1", s[1], tx);
        end
    endtask

    task automatic test_reset;
        logic [7:0] v;
        reset_n = 1'b0; rx = 1'b1;
        cs = 1'b0; rd = 1'b0; wren = 1'b0; address = 2'd0; data_wr = 8'h00;
        repeat (5) @(posedge clock);
        #1;
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_lines: tx=%b irq=%b expected 1 0", tx, irq);
        end
        reset_n = 1'b1;
        @(posedge clock); #1;
        peek(2'd1, v);
        n_checks++;
        if (v !== 8'h02) begin n_fail++; $display("FAIL reset_status: got %h expected 02", v); end
        peek(2'd2, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 00", v); end
        peek(2'd0, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", v); end
        peek(2'd3, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reserved_read: got %h expected 00", v); end
    endtask

    task automatic test_tx;
        check_tx(8'hA5, 1'b1);
    endtask

    task automatic test_tx_random;
        for (int i = 0; i < 2; i++) check_tx(8'($urandom), 1'b0);
    endtask

    task automatic test_rx_irq;
        logic [7:0] v;
        bus_write(2'd2, 8'h01);
        peek(2'd2, v);
        n_checks++;
        if (v !== 8'h01) begin n_fail++; $display("FAIL ctrl_readback: got %h expected 01", v); end
        send_frame(8'h3C, 1'b1);
        model_rx(8'h3C, 1'b1);
        peek(2'd1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL rx_status: got %h expected %h", v, exp_status()); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL rx_irq: got %b expected 1", irq); end
        bus_pop(v);
        n_checks++;
        if (v !== model_q[0]) begin n_fail++; $display("FAIL rx_data: got %h expected %h", v, model_q[0]); end
        void'(model_q.pop_front());
        peek(2'd1, v);
        n_checks++;
        if (v !== 8'h02) begin n_fail++; $display("FAIL rx_status_after_pop: got %h expected 02", v); end
        @(posedge clock); #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_pop: got %b expected 0", irq); end
    endtask

    task automatic test_rx_random;
        logic [7:0] b, v;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_rx(b, 1'b1);
        end
        peek(2'd1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL rand_status: got %h expected %h", v, exp_status()); end
        while (model_q.size() != 0) begin
            bus_pop(v);
            n_checks++;
            if (v !== model_q[0]) begin n_fail++; $display("FAIL rand_data: got %h expected %h", v, model_q[0]); end
            void'(model_q.pop_front());
        end
    endtask

    task automatic test_framing;
        logic [7:0] v;
        send_frame(8'($urandom), 1'b0);
        model_rx(8'h00, 1'b0);
        repeat (6) @(posedge clock);
        #1;
        peek(2'd1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL ferr_status: got %h expected %h", v, exp_status()); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL ferr_irq: got %b expected 1", irq); end
        bus_write(2'd1, 8'h08);
        m_ferr = 1'b0;
        peek(2'd1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL ferr_clear: got %h expected %h", v, exp_status()); end
    endtask

    task automatic test_glitch;
        logic [7:0] v;
        rx = 1'b0;
        repeat (50) @(posedge clock);
        #1;
        rx = 1'b1;
        repeat (300) @(posedge clock);
        #1;
        peek(2'd1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL glitch_status: got %h expected %h", v, exp_status()); end
    endtask

    task automatic test_overflow;
        logic [7:0] v;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1);
            model_rx(8'(i), 1'b1);
        end
        peek(2'd1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL ovr_status: got %h expected %h", v, exp_status()); end
        bus_write(2'd1, 8'h04);
        m_ovr = 1'b0;
        peek(2'd1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL ovr_clear: got %h expected %h", v, exp_status()); end
    endtask

    // Full FIFO: the last stop-bit sample lands on the same edge as a DATA pop
    task automatic test_back_to_back;
        logic [7:0] v, head;
        head = model_q[0];
        fork
            send_frame(8'h11, 1'b1);
            begin
                repeat (2064) @(posedge clock);
                #1;
                cs = 1'b1; rd = 1'b1; address = 2'd0;
                #1;
                v = q;
                @(posedge clock); #1;
                cs = 1'b0; rd = 1'b0;
            end
        join
        n_checks++;
        if (v !== head) begin n_fail++; $display("FAIL b2b_pop: got %h expected %h", v, head); end
        void'(model_q.pop_front());
        model_rx(8'h11, 1'b1);
        peek(2'd1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL b2b_status: got %h expected %h", v, exp_status()); end
        n_checks++;
        if (model_q.size() !== 16) begin n_fail++; $display("FAIL b2b_model_depth: got %0d expected 16", model_q.size()); end
        while (model_q.size() != 0) begin
            bus_pop(v);
            n_checks++;
            if (v !== model_q[0]) begin n_fail++; $display("FAIL b2b_order: got %h expected %h", v, model_q[0]); end
            void'(model_q.pop_front());
        end
        bus_pop(v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL empty_pop: got %h expected 00", v); end
        peek(2'd1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL drained_status: got %h expected %h", v, exp_status()); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] v;
        send_frame(8'($urandom), 1'b1);
        bus_write(2'd0, 8'h00);
        repeat (300) @(posedge clock);
        #1;
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_tx: got %b expected 0", tx); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: tx=%b irq=%b expected 1 0", tx, irq);
        end
        model_q.delete();
        m_ovr = 1'b0; m_ferr = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        peek(2'd1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL post_reset_status: got %h expected %h", v, exp_status()); end
        peek(2'd2, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL post_reset_ctrl: got %h expected 00", v); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_tx_random();
        test_rx_irq();
        test_rx_random();
        test_framing();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
